// File: rtl/alu_seq_ctrl.sv
// ALU command sequencer: single-cycle ops plus 32-step shift-add multiply.
// Define ALU_SEQ_MULH_EN to make op 110 (MULH, high product word) legal.

module alu_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctl,
    output logic [31:0] o_y,
    output logic        o_carry,
    output logic        o_ovf
);
    logic        w_sub;
    logic [31:0] w_b;
    logic [32:0] w_sum;
    logic        w_ovf;

    always_comb begin
        w_sub   = (i_ctl == 4'b0110) || (i_ctl == 4'b0111);
        w_b     = w_sub ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b} + {32'd0, w_sub};
        w_ovf   = (i_a[31] == w_b[31]) && (w_sum[31] != i_a[31]);
        o_y     = 32'd0;
        o_carry = 1'b0;
        o_ovf   = 1'b0;
        unique case (i_ctl)
            4'b0000: o_y = i_a & i_b;
            4'b0001: o_y = i_a | i_b;
            4'b0010, 4'b0110: begin
                o_y     = w_sum[31:0];
                o_carry = w_sum[32];
                o_ovf   = w_ovf;
            end
            4'b0111: o_y = {31'd0, w_sum[31] ^ w_ovf};
            default: o_y = 32'd0;
        endcase
    end
endmodule

module alu_seq_ctrl #(
    parameter int ZERO_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_carry,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        busy
);
`ifdef ALU_SEQ_MULH_EN
    localparam bit MULH_EN = 1'b1;
`else
    localparam bit MULH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mcand;
    logic [4:0]  r_cnt;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;
    logic        r_rsp_carry;
    logic        r_rsp_ovf;
    logic        r_rsp_err;

    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [3:0]  w_alu_ctl;
    logic [31:0] w_alu_y;
    logic        w_alu_c;
    logic        w_alu_v;
    logic        w_mul_cmd;
    logic        w_simple;
    logic        w_bypass;
    logic [31:0] w_hi_nx;
    logic [31:0] w_lo_nx;
    logic [31:0] w_mul_res;

    // ALU is shared: command operands in IDLE, hi+mcand while multiplying
    always_comb begin
        w_alu_a   = cmd_a;
        w_alu_b   = cmd_b;
        w_alu_ctl = 4'b0000;
        if (r_state == S_MUL) begin
            w_alu_a   = r_hi;
            w_alu_b   = r_mcand;
            w_alu_ctl = 4'b0010;
        end else begin
            unique case (cmd_op)
                3'b000:  w_alu_ctl = 4'b0000;
                3'b001:  w_alu_ctl = 4'b0001;
                3'b010:  w_alu_ctl = 4'b0010;
                3'b011:  w_alu_ctl = 4'b0110;
                3'b100:  w_alu_ctl = 4'b0111;
                default: w_alu_ctl = 4'b0000;
            endcase
        end
    end

    alu_32 u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_alu_b),
        .i_ctl   (w_alu_ctl),
        .o_y     (w_alu_y),
        .o_carry (w_alu_c),
        .o_ovf   (w_alu_v)
    );

    always_comb begin
        w_simple  = (cmd_op <= 3'b100);
        w_mul_cmd = (cmd_op == 3'b101) || (MULH_EN && cmd_op == 3'b110);
        w_bypass  = (ZERO_BYPASS != 0) && ((cmd_a == 32'd0) || (cmd_b == 32'd0));
        if (r_lo[0]) begin
            w_hi_nx = {w_alu_c, w_alu_y[31:1]};
            w_lo_nx = {w_alu_y[0], r_lo[31:1]};
        end else begin
            w_hi_nx = {1'b0, r_hi[31:1]};
            w_lo_nx = {r_hi[0], r_lo[31:1]};
        end
        w_mul_res = (r_op == 3'b110) ? w_hi_nx : w_lo_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 3'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_mcand      <= 32'd0;
            r_cnt        <= 5'd0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_mul_cmd && !w_bypass) begin
                            r_hi    <= 32'd0;
                            r_lo    <= cmd_b;
                            r_mcand <= cmd_a;
                            r_cnt   <= 5'd0;
                            r_state <= S_MUL;
                        end else begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            if (w_simple) begin
                                r_rsp_result <= w_alu_y;
                                r_rsp_zero   <= (w_alu_y == 32'd0);
                                r_rsp_carry  <= w_alu_c;
                                r_rsp_ovf    <= w_alu_v;
                                r_rsp_err    <= 1'b0;
                            end else begin
                                r_rsp_result <= 32'd0;
                                r_rsp_zero   <= 1'b1;
                                r_rsp_carry  <= 1'b0;
                                r_rsp_ovf    <= 1'b0;
                                r_rsp_err    <= !w_mul_cmd;
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state      <= S_DONE;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= w_mul_res;
                        r_rsp_zero   <= (w_mul_res == 32'd0);
                        r_rsp_carry  <= 1'b0;
                        r_rsp_ovf    <= (w_hi_nx != 32'd0);
                        r_rsp_err    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;
endmodule
